deal_sequencer: RTL and testbench

Single-clock controller that sequences the baccarat card datapath from the 50 MHz clock. It replaces the key-clocked round state machine. It issues one-cycle load strobes for the six card slots, applies the natural rule and the third-card rules using the datapath scores, and signals end of round and the winner to the balance logic and LEDs. Advances come from a pulsed step request or from an internal auto-play timer.

---
 rtl/deal_sequencer_pkg.sv | 43 ++++
 rtl/deal_sequencer_if.sv | 37 +++
 rtl/deal_sequencer_adv_timer.sv | 56 +++++
 rtl/deal_sequencer.sv | 111 +++++++++++
 tb/tb_deal_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/deal_sequencer_pkg.sv
// Shared types and rule helpers for the baccarat round sequencer.
// Card slots are indexed in deal order so a strobe vector is one-hot in that order.
package deal_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_P1   = 3'd1,
      ST_D1   = 3'd2,
      ST_P2   = 3'd3,
      ST_D2   = 3'd4,
      ST_P3   = 3'd5,
      ST_D3   = 3'd6,
      ST_END  = 3'd7
   } state_e;

   localparam logic [3:0] NATURAL_MIN      = 4'd8;
   localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
   localparam logic [3:0] DEALER_STAND     = 4'd7;

   localparam int SB_PC1 = 0;
   localparam int SB_DC1 = 1;
   localparam int SB_PC2 = 2;
   localparam int SB_DC2 = 3;
   localparam int SB_PC3 = 4;
   localparam int SB_DC3 = 5;

   // Dealer third-card tableau, used only after the player has drawn a third card.
   function automatic logic dealer_draws(input logic [3:0] dscore, input logic [3:0] pcard3);
      logic draw;
      draw = 1'b0;
      if (dscore < DEALER_STAND) begin
         case (dscore)
            4'd3:    draw = (pcard3 != 4'd8);
            4'd4:    draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:    draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:    draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
            default: draw = 1'b1;
         endcase
      end
      return draw;
   endfunction

endpackage

// File: rtl/deal_sequencer_if.sv
// Control/status bundle between the round sequencer and the card datapath/display.
// master drives requests and scores; slave (the sequencer) drives strobes and status.
interface deal_sequencer_if;
   import deal_pkg::*;

   logic       step;
   logic       auto;
   logic [3:0] pscore;
   logic [3:0] dscore;
   logic [3:0] pcard3;
   logic       load_pcard1;
   logic       load_pcard2;
   logic       load_pcard3;
   logic       load_dcard1;
   logic       load_dcard2;
   logic       load_dcard3;
   logic       endround;
   logic       player_win_light;
   logic       dealer_win_light;
   logic       busy;
   logic [2:0] state_out;

   modport master (
      output step, auto, pscore, dscore, pcard3,
      input  load_pcard1, load_pcard2, load_pcard3,
      input  load_dcard1, load_dcard2, load_dcard3,
      input  endround, player_win_light, dealer_win_light, busy, state_out
   );

   modport slave (
      input  step, auto, pscore, dscore, pcard3,
      output load_pcard1, load_pcard2, load_pcard3,
      output load_dcard1, load_dcard2, load_dcard3,
      output endround, player_win_light, dealer_win_light, busy, state_out
   );

endinterface

// File: rtl/deal_sequencer_adv_timer.sv
// Score-settle guard and auto-play timer; busy covers the strobe cycle plus SCORE_LAT-1 after.
// auto_expire fires once the current state has been held AUTO_DELAY cycles.
module adv_timer #(
   parameter int SCORE_LAT  = 2,
   parameter int AUTO_DELAY = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic auto_i,
   input  logic adv_i,
   input  logic in_end_i,
   input  logic load_i,
   output logic busy_o,
   output logic auto_expire_o
);

   localparam int GW = (SCORE_LAT < 1) ? 1 : $clog2(SCORE_LAT + 1);
   localparam int AW = (AUTO_DELAY < 2) ? 1 : $clog2(AUTO_DELAY);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_DELAY - 1);

   logic [GW-1:0] guard_q, guard_d;
   logic [AW-1:0] auto_q, auto_d;

   always_comb begin
      guard_d = guard_q;
      if (load_i) begin
         guard_d = GW'(SCORE_LAT);
      end else if (guard_q != '0) begin
         guard_d = guard_q - GW'(1);
      end
   end

   // Saturates at the last count so a blocked expiry stays pending until the guard clears.
   always_comb begin
      auto_d = auto_q;
      if (!auto_i || adv_i) begin
         auto_d = '0;
      end else if (!in_end_i && auto_q != AUTO_LAST) begin
         auto_d = auto_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         guard_q <= '0;
         auto_q  <= '0;
      end else begin
         guard_q <= guard_d;
         auto_q  <= auto_d;
      end
   end

   assign busy_o        = (guard_q != '0);
   assign auto_expire_o = auto_i && (auto_q == AUTO_LAST);

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat round FSM: one registered load strobe per advance, natural/third-card rules, winner lights.
// Advances (step or auto expiry) arriving while busy or in END are dropped, never queued.
module deal_sequencer
   import deal_pkg::*;
#(
   parameter int SCORE_LAT  = 2,
   parameter int AUTO_DELAY = 50000000
) (
   input  logic            fast_clock,
   input  logic            reset,
   deal_sequencer_if.slave sif
);

   state_e     state_q, state_d;
   logic [5:0] strobe_q, strobe_d;
   logic       endround_q, endround_d;
   logic       plight_q, plight_d;
   logic       dlight_q, dlight_d;
   logic       busy;
   logic       auto_expire;
   logic       adv;

   assign adv = (sif.step | auto_expire) & ~busy & (state_q != ST_END);

   always_comb begin
      state_d    = state_q;
      strobe_d   = '0;
      endround_d = 1'b0;
      plight_d   = plight_q;
      dlight_d   = dlight_q;
      if (adv) begin
         case (state_q)
            ST_IDLE: begin state_d = ST_P1; strobe_d[SB_PC1] = 1'b1; end
            ST_P1:   begin state_d = ST_D1; strobe_d[SB_DC1] = 1'b1; end
            ST_D1:   begin state_d = ST_P2; strobe_d[SB_PC2] = 1'b1; end
            ST_P2:   begin state_d = ST_D2; strobe_d[SB_DC2] = 1'b1; end
            ST_D2: begin
               if (sif.pscore >= NATURAL_MIN || sif.dscore >= NATURAL_MIN) begin
                  state_d = ST_END;
               end else if (sif.pscore < PLAYER_STAND_MIN) begin
                  state_d = ST_P3;
                  strobe_d[SB_PC3] = 1'b1;
               end else if (sif.dscore < PLAYER_STAND_MIN) begin
                  state_d = ST_D3;
                  strobe_d[SB_DC3] = 1'b1;
               end else begin
                  state_d = ST_END;
               end
            end
            ST_P3: begin
               if (dealer_draws(sif.dscore, sif.pcard3)) begin
                  state_d = ST_D3;
                  strobe_d[SB_DC3] = 1'b1;
               end else begin
                  state_d = ST_END;
               end
            end
            default: state_d = ST_END;
         endcase
         // Lights latch from the scores seen on the advance that enters END; a tie lights both.
         if (state_d == ST_END) begin
            endround_d = 1'b1;
            plight_d   = (sif.pscore >= sif.dscore);
            dlight_d   = (sif.dscore >= sif.pscore);
         end
      end
   end

   always_ff @(posedge fast_clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         strobe_q   <= '0;
         endround_q <= 1'b0;
         plight_q   <= 1'b0;
         dlight_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         strobe_q   <= strobe_d;
         endround_q <= endround_d;
         plight_q   <= plight_d;
         dlight_q   <= dlight_d;
      end
   end

   adv_timer #(
      .SCORE_LAT  (SCORE_LAT),
      .AUTO_DELAY (AUTO_DELAY)
   ) u_adv_timer (
      .clk           (fast_clock),
      .rst           (reset),
      .auto_i        (sif.auto),
      .adv_i         (adv),
      .in_end_i      (state_q == ST_END),
      .load_i        (|strobe_d),
      .busy_o        (busy),
      .auto_expire_o (auto_expire)
   );

   assign sif.load_pcard1      = strobe_q[SB_PC1];
   assign sif.load_dcard1      = strobe_q[SB_DC1];
   assign sif.load_pcard2      = strobe_q[SB_PC2];
   assign sif.load_dcard2      = strobe_q[SB_DC2];
   assign sif.load_pcard3      = strobe_q[SB_PC3];
   assign sif.load_dcard3      = strobe_q[SB_DC3];
   assign sif.endround         = endround_q;
   assign sif.player_win_light = plight_q;
   assign sif.dealer_win_light = dlight_q;
   assign sif.busy             = busy;
   assign sif.state_out        = state_q;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer with SCORE_LAT=2, AUTO_DELAY=4.
module tb_deal_sequencer;

   logic fast_clock = 1'b0;
   logic reset      = 1'b1;
   always #5 fast_clock = ~fast_clock;

   deal_sequencer_if sif ();

   deal_sequencer #(
      .SCORE_LAT  (2),
      .AUTO_DELAY (4)
   ) dut (
      .fast_clock (fast_clock),
      .reset      (reset),
      .sif        (sif)
   );

   localparam logic [5:0] PC1 = 6'b000001;
   localparam logic [5:0] DC1 = 6'b000010;
   localparam logic [5:0] PC2 = 6'b000100;
   localparam logic [5:0] DC2 = 6'b001000;
   localparam logic [5:0] PC3 = 6'b010000;
   localparam logic [5:0] DC3 = 6'b100000;
   localparam logic [5:0] NONE = 6'b000000;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] strb();
      return {sif.load_dcard3, sif.load_pcard3, sif.load_dcard2,
              sif.load_pcard2, sif.load_dcard1, sif.load_pcard1};
   endfunction

   // Moves to 1 ns after the next rising edge: outputs settled, inputs applied for this cycle.
   task automatic tick();
      @(posedge fast_clock);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      sif.step   = 1'b0;
      sif.auto   = 1'b0;
      sif.pscore = 4'd0;
      sif.dscore = 4'd0;
      sif.pcard3 = 4'd0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Step that must produce exp_s, then the two-cycle guard, then readiness.
   task automatic step_adv(input string tag, input logic [5:0] exp_s, input logic [2:0] exp_st);
      sif.step = 1'b1;
      tick();
      sif.step = 1'b0;
      chk({tag, "_strobe"}, 32'(strb()), 32'(exp_s));
      chk({tag, "_state"}, 32'(sif.state_out), 32'(exp_st));
      chk({tag, "_busy1"}, 32'(sif.busy), 32'd1);
      tick();
      chk({tag, "_strobe_off"}, 32'(strb()), 32'(NONE));
      chk({tag, "_busy2"}, 32'(sif.busy), 32'd1);
      tick();
      chk({tag, "_ready"}, 32'(sif.busy), 32'd0);
   endtask

   task automatic go_end(input string tag, input logic exp_p, input logic exp_d);
      sif.step = 1'b1;
      tick();
      sif.step = 1'b0;
      chk({tag, "_state"}, 32'(sif.state_out), 32'd7);
      chk({tag, "_strobe"}, 32'(strb()), 32'(NONE));
      chk({tag, "_endround"}, 32'(sif.endround), 32'd1);
      chk({tag, "_plight"}, 32'(sif.player_win_light), 32'(exp_p));
      chk({tag, "_dlight"}, 32'(sif.dealer_win_light), 32'(exp_d));
      tick();
      chk({tag, "_endround_off"}, 32'(sif.endround), 32'd0);
   endtask

   task automatic deal_four(input string tag);
      step_adv({tag, "_p1"}, PC1, 3'd1);
      step_adv({tag, "_d1"}, DC1, 3'd2);
      step_adv({tag, "_p2"}, PC2, 3'd3);
      step_adv({tag, "_d2"}, DC2, 3'd4);
   endtask

   initial begin
      do_reset();
      chk("rst_state", 32'(sif.state_out), 32'd0);
      chk("rst_strobe", 32'(strb()), 32'(NONE));
      chk("rst_endround", 32'(sif.endround), 32'd0);
      chk("rst_lights", 32'({sif.player_win_light, sif.dealer_win_light}), 32'd0);
      chk("rst_busy", 32'(sif.busy), 32'd0);

      // Player natural 9 against 3: no third cards, player wins.
      deal_four("nat");
      sif.pscore = 4'd9;
      sif.dscore = 4'd3;
      go_end("nat_end", 1'b1, 1'b0);

      // END is sticky against both step and auto.
      sif.step = 1'b1;
      sif.auto = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("sticky_strobe", 32'({strb(), sif.endround}), 32'd0);
      end
      sif.step = 1'b0;
      sif.auto = 1'b0;
      chk("sticky_state", 32'(sif.state_out), 32'd7);
      chk("sticky_lights", 32'({sif.player_win_light, sif.dealer_win_light}), 32'b10);

      // Player draws on 4, dealer on 6 draws against player third card 6.
      do_reset();
      deal_four("pd");
      sif.pscore = 4'd4;
      sif.dscore = 4'd6;
      step_adv("pd_p3", PC3, 3'd5);
      sif.pcard3 = 4'd6;
      step_adv("pd_d3", DC3, 3'd6);
      go_end("pd_end", 1'b0, 1'b1);

      // Dealer on 3 stands against player third card 8; equal scores tie.
      do_reset();
      deal_four("tie");
      sif.pscore = 4'd4;
      sif.dscore = 4'd6;
      step_adv("tie_p3", PC3, 3'd5);
      sif.pcard3 = 4'd8;
      sif.pscore = 4'd3;
      sif.dscore = 4'd3;
      go_end("tie_end", 1'b1, 1'b1);

      // Steps during the guard window are dropped; the first step after it advances.
      do_reset();
      sif.step = 1'b1;
      tick();
      chk("guard_p1", 32'(strb()), 32'(PC1));
      tick();
      chk("guard_hold_state", 32'(sif.state_out), 32'd1);
      chk("guard_hold_strobe", 32'(strb()), 32'(NONE));
      chk("guard_hold_busy", 32'(sif.busy), 32'd1);
      tick();
      chk("guard_hold2_state", 32'(sif.state_out), 32'd1);
      chk("guard_hold2_busy", 32'(sif.busy), 32'd0);
      tick();
      sif.step = 1'b0;
      chk("guard_adv_state", 32'(sif.state_out), 32'd2);
      chk("guard_adv_strobe", 32'(strb()), 32'(DC1));

      // Auto play: strobes land exactly four cycles apart.
      do_reset();
      sif.auto   = 1'b1;
      sif.pscore = 4'd4;
      sif.dscore = 4'd6;
      begin
         logic [5:0] exp_tbl [4];
         exp_tbl[0] = PC1;
         exp_tbl[1] = DC1;
         exp_tbl[2] = PC2;
         exp_tbl[3] = DC2;
         for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
               tick();
               chk("auto_gap", 32'(strb()), 32'(NONE));
            end
            tick();
            chk("auto_strobe", 32'(strb()), 32'(exp_tbl[k]));
            chk("auto_state", 32'(sif.state_out), 32'(k + 1));
         end
      end
      // Step lands on the same cycle as the expiry: one advance only.
      tick();
      tick();
      tick();
      sif.step = 1'b1;
      tick();
      sif.step = 1'b0;
      chk("coincide_strobe", 32'(strb()), 32'(PC3));
      chk("coincide_state", 32'(sif.state_out), 32'd5);
      tick();
      chk("coincide_once_state", 32'(sif.state_out), 32'd5);
      chk("coincide_once_strobe", 32'(strb()), 32'(NONE));
      sif.auto = 1'b0;
      tick();

      // Reset on the advance cycle in P3 wins over the pending dealer strobe.
      sif.dscore = 4'd0;
      sif.step   = 1'b1;
      reset      = 1'b1;
      tick();
      sif.step = 1'b0;
      chk("midrst_state", 32'(sif.state_out), 32'd0);
      chk("midrst_strobe", 32'(strb()), 32'(NONE));
      chk("midrst_lights", 32'({sif.player_win_light, sif.dealer_win_light}), 32'd0);
      chk("midrst_busy", 32'(sif.busy), 32'd0);
      reset = 1'b0;
      tick();
      chk("midrst_after", 32'({strb(), sif.state_out}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
